platform_spawner: RTL and testbench

Owns the platform table consumed by the collision observer and the renderer: it drives `platforms` and `platform_activation`. Once per frame it scrolls every active platform down by the camera scroll amount and retires platforms that leave the bottom of the screen. It then refills free slots above the screen with platforms at LFSR-random x positions. After reset it builds the initial layout itself.

---
 rtl/platform_spawner.sv | 117 +++++++++++
 tb/tb_platform_spawner.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/platform_spawner.sv
// platform_spawner: owns the platform table; each frame scrolls and retires platforms, then refills
// free slots above the screen at LFSR-random x positions. Builds the initial layout out of reset.
module platform_spawner #(
  parameter int N_PLATFORMS = 93,
  parameter int SCREEN_W = 1024,
  parameter int SCREEN_H = 768,
  parameter int PLAT_W = 100,
  parameter int SPAWN_GAP = 64,
  parameter int GROUND_Y = 690,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_tick,
  input  logic [9:0] scroll_dy,
  output logic signed [N_PLATFORMS-1:0][1:0][10:0] platforms,
  output logic [N_PLATFORMS-1:0] platform_activation,
  output logic signed [10:0] top_y,
  output logic busy,
  output logic frame_done
);
  localparam int IW = $clog2(N_PLATFORMS);
  localparam logic signed [11:0] H12 = 12'(SCREEN_H);
  localparam logic signed [10:0] GAP = 11'(SPAWN_GAP);
  localparam logic [9:0] XMAX = 10'(SCREEN_W - PLAT_W);
  typedef enum logic [1:0] {IDLE, SCROLL, SPAWN, DONE} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [9:0] dy_q, dy_d;
  logic [N_PLATFORMS-1:0][1:0][10:0] plat_q, plat_d;
  logic [N_PLATFORMS-1:0] act_q, act_d;
  logic signed [10:0] top_q, top_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic done_q, done_d, busy_q, busy_d;
  logic last;
  logic signed [11:0] sum, top_sum;
  logic signed [10:0] top_sat, spawn_y;
  logic [9:0] xs;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    dy_d = dy_q;
    plat_d = plat_q;
    act_d = act_q;
    top_d = top_q;
    done_d = 1'b0;
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    last = idx_q == IW'(N_PLATFORMS - 1);
    sum = $signed({plat_q[idx_q][0][10], plat_q[idx_q][0]}) + $signed({2'b00, dy_q});
    top_sum = $signed({top_q[10], top_q}) + $signed({2'b00, dy_q});
    top_sat = (top_sum >= H12) ? 11'(SCREEN_H) : top_sum[10:0];
    spawn_y = top_q - GAP;
    xs = (lfsr_q[9:0] > XMAX) ? lfsr_q[9:0] - XMAX : lfsr_q[9:0];
    case (state_q)
      IDLE: if (frame_tick) begin
        dy_d = scroll_dy;
        idx_d = '0;
        state_d = SCROLL;
      end
      SCROLL: begin
        if (act_q[idx_q]) begin
          if (sum >= H12) act_d[idx_q] = 1'b0;
          else plat_d[idx_q][0] = sum[10:0];
        end
        idx_d = last ? '0 : idx_q + 1'b1;
        if (last) begin
          top_d = top_sat;
          state_d = SPAWN;
        end
      end
      SPAWN: begin
        // single ascending pass; top_q carries the height chosen for the previous spawn
        if (!act_q[idx_q] && !top_q[10]) begin
          plat_d[idx_q][0] = spawn_y;
          plat_d[idx_q][1] = {1'b0, xs};
          act_d[idx_q] = 1'b1;
          top_d = spawn_y;
        end
        idx_d = last ? '0 : idx_q + 1'b1;
        state_d = last ? DONE : SPAWN;
        done_d = last;
      end
      DONE: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SPAWN;
      idx_q <= '0;
      dy_q <= '0;
      plat_q <= '0;
      plat_q[0][0] <= 11'(GROUND_Y);
      plat_q[0][1] <= 11'((SCREEN_W - PLAT_W) / 2);
      act_q <= N_PLATFORMS'(1);
      top_q <= 11'(GROUND_Y);
      lfsr_q <= LFSR_SEED;
      done_q <= 1'b0;
      busy_q <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      dy_q <= dy_d;
      plat_q <= plat_d;
      act_q <= act_d;
      top_q <= top_d;
      lfsr_q <= lfsr_d;
      done_q <= done_d;
      busy_q <= busy_d;
    end
  end
  assign platforms = plat_q;
  assign platform_activation = act_q;
  assign top_y = top_q;
  assign busy = busy_q;
  assign frame_done = done_q;
endmodule

// File: tb/tb_platform_spawner.sv
// tb_platform_spawner: directed scenarios plus random-scroll frames checked against a
// slot-table reference model that replays scroll/retire/refill rules per frame.
module tb_platform_spawner;
  localparam int N = 93;
  logic clk = 1'b0, rst = 1'b0, frame_tick = 1'b0;
  logic [9:0] scroll_dy = '0;
  logic signed [N-1:0][1:0][10:0] platforms;
  logic [N-1:0] platform_activation;
  logic signed [10:0] top_y;
  logic busy, frame_done;
  int errors = 0, checks = 0, cnt;
  int my[N], mx[N], mtop;
  bit ma[N];
  platform_spawner dut (.clk(clk), .rst(rst), .frame_tick(frame_tick), .scroll_dy(scroll_dy),
    .platforms(platforms), .platform_activation(platform_activation), .top_y(top_y),
    .busy(busy), .frame_done(frame_done));
  always #5 clk = ~clk;
  always @(posedge clk or negedge rst) cnt <= !rst ? 0 : cnt + 1;
  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic logic [15:0] step(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction
  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      my[i] = 0; mx[i] = 0; ma[i] = 0;
    end
    my[0] = 690; mx[0] = 462; ma[0] = 1; mtop = 690;
  endtask
  task automatic model_scroll(input int dy);
    for (int i = 0; i < N; i++)
      if (ma[i]) begin
        if (my[i] + dy >= 768) ma[i] = 0;
        else my[i] += dy;
      end
    mtop = (mtop + dy > 768) ? 768 : mtop + dy;
  endtask
  task automatic model_spawn(input int b);
    logic [15:0] l = 16'hACE1;
    int v;
    for (int n = 0; n < b; n++) l = step(l);
    for (int i = 0; i < N; i++) begin
      v = int'(l[9:0]);
      if (!ma[i] && mtop >= 0) begin
        mtop -= 64; my[i] = mtop; mx[i] = v > 924 ? v - 924 : v; ma[i] = 1;
      end
      l = step(l);
    end
  endtask
  task automatic check_table(input string tag);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s_slot%0d", tag, i),
            {9'b0, platform_activation[i], platforms[i][0], platforms[i][1]},
            {9'b0, ma[i], 11'(my[i]), 11'(mx[i])});
      if (platform_activation[i]) check($sformatf("%s_xrange%0d", tag, i), 32'(platforms[i][1] <= 924), 1);
    end
    check({tag, "_top_y"}, $signed(top_y), mtop);
  endtask
  task automatic release_and_check();
    int k;
    @(negedge clk);
    rst = 1'b1;
    model_spawn(0);
    k = 1;
    while (frame_done !== 1'b1 && k <= 4 * N) begin
      @(negedge clk);
      k++;
    end
    check("init_done_cycle", k, N + 1);
    @(negedge clk);
    check("init_idle", 32'(busy), 0);
    check_table("init");
    check("init_slot11_y", $signed(platforms[11][0]), -14);
    check("init_top", $signed(top_y), -14);
    check("init_act_lo", platform_activation[31:0], 32'hFFF);
    check("init_act_hi", 32'(|platform_activation[N-1:32]), 0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    frame_tick = 1'b0;
    model_reset();
    release_and_check();
  endtask
  task automatic frame(input string tag, input int dy, input int second);
    int k, busy_n, done_n, done_at, e;
    @(negedge clk);
    frame_tick = 1'b1;
    scroll_dy = 10'(dy);
    @(negedge clk);
    frame_tick = 1'b0;
    e = cnt;
    model_scroll(dy);
    model_spawn(e + N);
    busy_n = 0; done_n = 0; done_at = 0;
    for (k = 1; k <= 2 * N + 6; k++) begin
      if (busy) busy_n++;
      if (frame_done) begin
        done_n++;
        if (done_at == 0) done_at = k;
      end
      frame_tick = (k == second);
      @(negedge clk);
    end
    frame_tick = 1'b0;
    check({tag, "_done_at"}, done_at, 2 * N + 1);
    check({tag, "_done_n"}, done_n, 1);
    check({tag, "_busy_n"}, busy_n, 2 * N + 1);
    check_table(tag);
  endtask
  initial begin
    int dy;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", 32'(busy), 1);
    check("rst_done", 32'(frame_done), 0);
    check_table("rst");
    release_and_check();
    frame("zero", 0, 0);
    do_reset();
    frame("s100", 100, 0);
    check("s100_slot0_y", $signed(platforms[0][0]), 22);
    check("s100_slot12_y", $signed(platforms[12][0]), -42);
    check("s100_slot13_act", 32'(platform_activation[13]), 0);
    check("s100_top", $signed(top_y), -42);
    do_reset();
    frame("busytick", 100, 5);
    do_reset();
    frame("s1023", 1023, 0);
    check("s1023_slot0_y", $signed(platforms[0][0]), 704);
    check("s1023_slot12_y", $signed(platforms[12][0]), -64);
    check("s1023_top", $signed(top_y), -64);
    @(negedge clk);
    frame_tick = 1'b1;
    scroll_dy = 10'd300;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1 model_reset();
    check("arst_busy", 32'(busy), 1);
    check("arst_done", 32'(frame_done), 0);
    check_table("arst");
    release_and_check();
    for (int f = 0; f < 10; f++) begin
      dy = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 200));
      frame($sformatf("rnd%0d", f), dy, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 2 * N)) : 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
